byte_to_word_streamer_v2: RTL and testbench

- Parametrised successor of the byte-to-word streamer: packs an 8-bit AXI-Stream byte stream into N_BYTES-wide words.
- Adds the following over the previous generation:
  - configurable word width and lane order;
  - TLAST-terminated partial words with TKEEP;
  - an idle-timeout flush of partial words;
  - traffic statistics counters.
- Sits between byte-oriented sources (UART/SPI bridges) and word-oriented DMA/FIFO sinks in the PL.

---
 rtl/byte_to_word_streamer_v2_pkg.sv | 20 ++
 rtl/byte_to_word_streamer_v2_out_reg.sv | 38 +++
 rtl/byte_to_word_streamer_v2.sv | 129 ++++++++++++
 tb/tb_byte_to_word_streamer_v2.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_to_word_streamer_v2_pkg.sv
// Shared constants and helpers for the byte-to-word streamer: lane mapping,
// lane-index width rule and statistics/timer widths.
package byte_to_word_pkg;

  localparam int unsigned STAT_WORDS_W   = 32;
  localparam int unsigned STAT_PARTIAL_W = 16;
  localparam int unsigned TIMER_W        = 16;

  function automatic int unsigned idx_width(input int unsigned n_bytes);
    return (n_bytes > 32'd1) ? $clog2(n_bytes) : 32'd1;
  endfunction

  // Lane that the idx-th byte of a word lands in
  function automatic int unsigned lane_of(input int unsigned idx,
                                          input int unsigned n_bytes,
                                          input logic        big_endian);
    return big_endian ? (n_bytes - 32'd1 - idx) : idx;
  endfunction

endpackage

// File: rtl/byte_to_word_streamer_v2_out_reg.sv
// One-deep AXI-Stream output register: holds data/keep/last while the sink
// stalls, drops valid on a handshake unless reloaded on the same edge.
module axis_word_out_reg
  import byte_to_word_pkg::*;
#(
  parameter int unsigned N_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [8*N_BYTES-1:0] load_data,
  input  logic [N_BYTES-1:0]   load_keep,
  input  logic                 load_last,
  input  logic                 tready,
  output logic [8*N_BYTES-1:0] tdata,
  output logic [N_BYTES-1:0]   tkeep,
  output logic                 tlast,
  output logic                 tvalid
);

  // Output word register with valid/ready holding
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tkeep  <= load_keep;
      tlast  <= load_last;
      tvalid <= 1'b1;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_to_word_streamer_v2.sv
// Packs an 8-bit AXI-Stream into N_BYTES-wide words with TLAST/TKEEP partial
// words, an optional idle-timeout flush and traffic statistics.
module byte_to_word_streamer_v2
  import byte_to_word_pkg::*;
#(
  parameter int unsigned N_BYTES    = 4,
  parameter bit          BIG_ENDIAN = 1'b0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [8*N_BYTES-1:0]      m_axis_tdata,
  output logic [N_BYTES-1:0]        m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [STAT_WORDS_W-1:0]   stat_words,
  output logic [STAT_PARTIAL_W-1:0] stat_partial
);

  localparam int unsigned          IDX_W     = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(N_BYTES - 32'd1);
  localparam logic [TIMER_W-1:0]   TIMEOUT_V = TIMER_W'(TIMEOUT);
  localparam logic [N_BYTES-1:0]   KEEP_ALL  = {N_BYTES{1'b1}};

  logic [IDX_W-1:0]          idx_r;
  logic [8*N_BYTES-1:0]      asm_data_r, data_next_s, load_data_s;
  logic [N_BYTES-1:0]        asm_keep_r, keep_next_s, load_keep_s;
  logic [TIMER_W-1:0]        timer_r;
  logic [STAT_WORDS_W-1:0]   stat_words_r;
  logic [STAT_PARTIAL_W-1:0] stat_partial_r;
  logic out_free_s, in_hs_s, out_hs_s, complete_s, flush_s, load_s, load_last_s;

  assign out_free_s    = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = out_free_s && !ARESET;
  assign in_hs_s       = s_axis_tvalid && s_axis_tready;
  assign out_hs_s      = m_axis_tvalid && m_axis_tready;
  assign complete_s    = in_hs_s && ((idx_r == IDX_LAST) || s_axis_tlast);
  // A byte presented on the flush cycle takes priority over the flush
  assign flush_s       = (TIMEOUT != 32'd0) && (timer_r == TIMEOUT_V) &&
                         (idx_r != '0) && out_free_s && !s_axis_tvalid;
  assign load_s        = complete_s || flush_s;
  assign stat_words    = stat_words_r;
  assign stat_partial  = stat_partial_r;

  // Merge the incoming byte into its lane and pick what the output register loads
  always_comb begin
    data_next_s = asm_data_r;
    keep_next_s = asm_keep_r;
    for (int unsigned l = 0; l < N_BYTES; l++) begin
      if (l == lane_of(32'(idx_r), N_BYTES, BIG_ENDIAN)) begin
        data_next_s[8*l +: 8] = s_axis_tdata;
        keep_next_s[l]        = 1'b1;
      end else begin
        data_next_s[8*l +: 8] = asm_data_r[8*l +: 8];
        keep_next_s[l]        = asm_keep_r[l];
      end
    end
    if (complete_s) begin
      load_data_s = data_next_s;
      load_keep_s = keep_next_s;
      load_last_s = s_axis_tlast;
    end else begin
      load_data_s = asm_data_r;
      load_keep_s = asm_keep_r;
      load_last_s = 1'b0;
    end
  end

  // Word assembly: lane index, partial data and keep
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      idx_r      <= '0;
      asm_data_r <= '0;
      asm_keep_r <= '0;
    end else if (load_s) begin
      idx_r      <= '0;
      asm_data_r <= '0;
      asm_keep_r <= '0;
    end else if (in_hs_s) begin
      idx_r      <= idx_r + IDX_W'(1);
      asm_data_r <= data_next_s;
      asm_keep_r <= keep_next_s;
    end
  end

  // Idle timer: restarts on every accepted byte or empty assembly, saturates
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      timer_r <= '0;
    end else if (in_hs_s || (idx_r == '0) || flush_s) begin
      timer_r <= '0;
    end else if (timer_r != TIMEOUT_V) begin
      timer_r <= timer_r + 16'd1;
    end
  end

  // Traffic statistics on output handshakes
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stat_words_r   <= '0;
      stat_partial_r <= '0;
    end else if (out_hs_s) begin
      stat_words_r <= stat_words_r + 32'd1;
      if ((m_axis_tkeep != KEEP_ALL) && (stat_partial_r != 16'hFFFF)) begin
        stat_partial_r <= stat_partial_r + 16'd1;
      end
    end
  end

  axis_word_out_reg #(.N_BYTES(N_BYTES)) u_out_reg (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (load_s),
    .load_data (load_data_s),
    .load_keep (load_keep_s),
    .load_last (load_last_s),
    .tready    (m_axis_tready),
    .tdata     (m_axis_tdata),
    .tkeep     (m_axis_tkeep),
    .tlast     (m_axis_tlast),
    .tvalid    (m_axis_tvalid)
  );

endmodule

// File: tb/tb_byte_to_word_streamer_v2.sv
// Scoreboard bench for byte_to_word_streamer_v2 over five configurations:
// N4 LE timeout 8, N4 LE no timeout (random), N4 BE, N1 and N8.
`timescale 1ns/1ps
module tb_byte_to_word_streamer_v2;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  typedef struct {
    int           id;
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  logic [4:0] rst, s_tvalid, m_rdy;
  logic [7:0] s_tdata;
  logic       s_tlast;

  logic        r0, v0, l0, r1, v1, l1, r2, v2, l2, r3, v3, l3, r4, v4, l4;
  logic [31:0] d0, d1, d2, w0, w1, w2, w3, w4;
  logic [7:0]  d3, k4;
  logic [63:0] d4;
  logic [3:0]  k0, k1, k2;
  logic [0:0]  k3;
  logic [15:0] p0, p1, p2, p3, p4;

  byte_to_word_streamer_v2 #(.N_BYTES(4), .BIG_ENDIAN(1'b0), .TIMEOUT(8)) dut0 (
    .ACLK(tb_ACLK), .ARESET(rst[0]), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tready(r0), .s_axis_tlast(s_tlast), .m_axis_tdata(d0), .m_axis_tkeep(k0),
    .m_axis_tvalid(v0), .m_axis_tready(m_rdy[0]), .m_axis_tlast(l0),
    .stat_words(w0), .stat_partial(p0));

  byte_to_word_streamer_v2 #(.N_BYTES(4), .BIG_ENDIAN(1'b0), .TIMEOUT(0)) dut1 (
    .ACLK(tb_ACLK), .ARESET(rst[1]), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tready(r1), .s_axis_tlast(s_tlast), .m_axis_tdata(d1), .m_axis_tkeep(k1),
    .m_axis_tvalid(v1), .m_axis_tready(m_rdy[1]), .m_axis_tlast(l1),
    .stat_words(w1), .stat_partial(p1));

  byte_to_word_streamer_v2 #(.N_BYTES(4), .BIG_ENDIAN(1'b1), .TIMEOUT(0)) dut2 (
    .ACLK(tb_ACLK), .ARESET(rst[2]), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[2]),
    .s_axis_tready(r2), .s_axis_tlast(s_tlast), .m_axis_tdata(d2), .m_axis_tkeep(k2),
    .m_axis_tvalid(v2), .m_axis_tready(m_rdy[2]), .m_axis_tlast(l2),
    .stat_words(w2), .stat_partial(p2));

  byte_to_word_streamer_v2 #(.N_BYTES(1), .BIG_ENDIAN(1'b0), .TIMEOUT(0)) dut3 (
    .ACLK(tb_ACLK), .ARESET(rst[3]), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[3]),
    .s_axis_tready(r3), .s_axis_tlast(s_tlast), .m_axis_tdata(d3), .m_axis_tkeep(k3),
    .m_axis_tvalid(v3), .m_axis_tready(m_rdy[3]), .m_axis_tlast(l3),
    .stat_words(w3), .stat_partial(p3));

  byte_to_word_streamer_v2 #(.N_BYTES(8), .BIG_ENDIAN(1'b0), .TIMEOUT(0)) dut4 (
    .ACLK(tb_ACLK), .ARESET(rst[4]), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[4]),
    .s_axis_tready(r4), .s_axis_tlast(s_tlast), .m_axis_tdata(d4), .m_axis_tkeep(k4),
    .m_axis_tvalid(v4), .m_axis_tready(m_rdy[4]), .m_axis_tlast(l4),
    .stat_words(w4), .stat_partial(p4));

  function automatic void exp_push(input int id, input logic [127:0] d,
                                   input logic [15:0] k, input logic l);
    exp_t e;
    e.id = id; e.d = d; e.k = k; e.l = l;
    exp_q.push_back(e);
  endfunction

  function automatic void check_word(input int id, input logic [127:0] d,
                                     input logic [15:0] k, input logic l);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL word dut%0d: got data=%h keep=%h last=%b, required no word", id, d, k, l);
    end else begin
      e = exp_q.pop_front();
      if (e.id != id || e.d !== d || e.k !== k || e.l !== l) begin
        n_fail++;
        $display("FAIL word: got dut%0d data=%h keep=%h last=%b, required dut%0d data=%h keep=%h last=%b",
                 id, d, k, l, e.id, e.d, e.k, e.l);
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_ACLK);
      #1;
    end
  endtask

  // Hold the byte until it is accepted; returns 1 ns after the accepting edge
  task automatic send(input int id, input logic [7:0] b, input logic l);
    logic hs;
    int   guard;
    guard = 0;
    s_tdata = b; s_tlast = l; s_tvalid[id] = 1'b1;
    forever begin
      @(negedge tb_ACLK);
      hs = (id == 0) ? r0 : (id == 1) ? r1 : (id == 2) ? r2 : (id == 3) ? r3 : r4;
      @(posedge tb_ACLK);
      #1;
      if (hs) break;
      guard++;
      if (guard > 2000) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout dut%0d: byte %h not accepted, required acceptance", id, b);
        break;
      end
    end
    s_tvalid[id] = 1'b0; s_tlast = 1'b0;
  endtask

  logic [31:0] md;
  logic [3:0]  mk;
  int          midx = 0, nw = 0, np = 0;

  task automatic model_send(input logic [7:0] b, input logic l);
    md[8*midx +: 8] = b;
    mk[midx] = 1'b1;
    if (midx == 3 || l) begin
      exp_push(1, 128'(md), 16'(mk), l);
      nw++;
      if (mk != 4'hF) np++;
      md = '0; mk = '0; midx = 0;
    end else begin
      midx++;
    end
    send(1, b, l);
  endtask

  // Monitor: every output handshake pops and checks the scoreboard
  always @(negedge tb_ACLK) begin
    if (v0 && m_rdy[0]) check_word(0, 128'(d0), 16'(k0), l0);
    if (v1 && m_rdy[1]) check_word(1, 128'(d1), 16'(k1), l1);
    if (v2 && m_rdy[2]) check_word(2, 128'(d2), 16'(k2), l2);
    if (v3 && m_rdy[3]) check_word(3, 128'(d3), 16'(k3), l3);
    if (v4 && m_rdy[4]) check_word(4, 128'(d4), 16'(k4), l4);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable;
    rst = 5'h1F; s_tvalid = 5'h00; m_rdy = 5'h1F; s_tdata = 8'h00; s_tlast = 1'b0;
    md = '0; mk = '0;
    tick(3);
    check("reset_tvalid", 64'(v0), 64'd0);
    check("reset_tdata", 64'(d0), 64'd0);
    check("reset_tkeep", 64'(k0), 64'd0);
    check("reset_tlast", 64'(l0), 64'd0);
    check("reset_words", 64'(w0), 64'd0);
    check("reset_partial", 64'(p0), 64'd0);
    check("reset_s_tready", 64'(r0), 64'd0);
    rst = 5'h00;
    tick(1);
    check("idle_s_tready", 64'(r0), 64'd1);

    // Full words, little-endian
    exp_push(0, 128'h04030201, 16'hF, 1'b0);
    exp_push(0, 128'h08070605, 16'hF, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      send(0, 8'(i), (i == 8));
      if (i == 4) check("latency_tvalid", 64'(v0), 64'd1);
    end
    tick(2);
    check("le_words", 64'(w0), 64'd2);
    check("le_partial", 64'(p0), 64'd0);

    // Idle-timeout flush
    exp_push(0, 128'h0000ADDE, 16'h3, 1'b0);
    send(0, 8'hDE, 1'b0);
    send(0, 8'hAD, 1'b0);
    tick(8);
    check("timeout_not_early", 64'(v0), 64'd0);
    tick(1);
    check("timeout_flush", 64'(v0), 64'd1);
    tick(1);
    check("timeout_partial", 64'(p0), 64'd1);

    // Byte arriving on the flush cycle is absorbed
    exp_push(0, 128'h40302010, 16'hF, 1'b0);
    send(0, 8'h10, 1'b0);
    send(0, 8'h20, 1'b0);
    tick(8);
    send(0, 8'h30, 1'b0);
    check("absorb_no_flush", 64'(v0), 64'd0);
    send(0, 8'h40, 1'b0);
    tick(2);
    check("absorb_words", 64'(w0), 64'd4);

    // Stalled word stays stable, then reset discards it
    m_rdy[0] = 1'b0;
    send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b0); send(0, 8'hA3, 1'b0); send(0, 8'hA4, 1'b0);
    stable = 1'b1;
    repeat (20) begin
      tick(1);
      if (v0 !== 1'b1 || d0 !== 32'hA4A3A2A1 || k0 !== 4'hF || r0 !== 1'b0) stable = 1'b0;
    end
    check("stall_stable", 64'(stable), 64'd1);
    rst[0] = 1'b1;
    tick(1);
    check("rst_stall_tvalid", 64'(v0), 64'd0);
    check("rst_words", 64'(w0), 64'd0);
    check("rst_partial", 64'(p0), 64'd0);
    rst[0] = 1'b0; m_rdy[0] = 1'b1;
    send(0, 8'h77, 1'b0); send(0, 8'h88, 1'b0);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    exp_push(0, 128'h44332211, 16'hF, 1'b0);
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b0); send(0, 8'h44, 1'b0);
    tick(2);
    check("post_rst_words", 64'(w0), 64'd1);

    // Big-endian partial word
    exp_push(2, 128'hABCDEF00, 16'hE, 1'b1);
    send(2, 8'hAB, 1'b0); send(2, 8'hCD, 1'b0); send(2, 8'hEF, 1'b1);
    tick(2);
    check("be_words", 64'(w2), 64'd1);
    check("be_partial", 64'(p2), 64'd1);

    // One-byte words
    exp_push(3, 128'h5A, 16'h1, 1'b0);
    exp_push(3, 128'hA5, 16'h1, 1'b1);
    send(3, 8'h5A, 1'b0); send(3, 8'hA5, 1'b1);
    tick(2);
    check("n1_words", 64'(w3), 64'd2);
    check("n1_partial", 64'(p3), 64'd0);

    // Eight-byte word
    exp_push(4, 128'h0807060504030201, 16'hFF, 1'b0);
    for (int i = 1; i <= 8; i++) send(4, 8'(i), 1'b0);
    tick(2);
    check("n8_words", 64'(w4), 64'd1);
    check("n8_partial", 64'(p4), 64'd0);

    // Long stall with a byte waiting, then random traffic and backpressure
    m_rdy[1] = 1'b0;
    model_send(8'hC1, 1'b0); model_send(8'hC2, 1'b0); model_send(8'hC3, 1'b0); model_send(8'hC4, 1'b0);
    stable = 1'b1;
    fork
      model_send(8'h55, 1'b0);
      begin
        repeat (20) begin
          tick(1);
          if (v1 !== 1'b1 || d1 !== 32'hC4C3C2C1 || r1 !== 1'b0) stable = 1'b0;
        end
        m_rdy[1] = 1'b1;
      end
    join
    check("stall1_stable", 64'(stable), 64'd1);
    fork
      begin
        while (!done) begin
          m_rdy[1] = ($urandom_range(3) != 0);
          tick(1);
        end
        m_rdy[1] = 1'b1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          model_send(8'($urandom), (i == 999) || ($urandom_range(7) == 0));
          if ($urandom_range(3) == 0) tick(1);
        end
        done = 1'b1;
      end
    join
    tick(5);
    check("rnd_words", 64'(w1), 64'(nw));
    check("rnd_partial", 64'(p1), 64'(np));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
